// File: rtl/fifo_rd_skid_pkg.sv
// Shared state encoding for two-entry (main + skid) valid/ready output stages.
package fifo_rd_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    localparam int unsigned SKID_DEPTH = 2;

    // The state encoding doubles as the held-entry count.
    function automatic logic [1:0] skid_occupancy(input skid_state_e st);
        return st;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Registered valid/ready read stage behind a first-word-fall-through fifo;
// main + skid entries keep m_ready_i off the fifo pop path.
module fifo_rd_skid
    import fifo_rd_skid_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [1:0]            occupancy_o
);

    skid_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, skid_q;
    logic                  pop, accept;
    logic                  load_main, main_from_skid, load_skid;

    // Pop depends only on registered state, so ready never reaches the fifo.
    assign pop    = !fifo_empty_i && (state_q != ST_TWO);
    assign accept = (state_q != ST_EMPTY) && m_ready_i;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (pop) begin
                    state_d   = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (pop && accept) begin
                    load_main = 1'b1;
                end else if (pop) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (accept) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (accept) begin
                    state_d        = ST_ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_q <= main_from_skid ? skid_q : fifo_data_i;
            end
            if (load_skid) begin
                skid_q <= fifo_data_i;
            end
        end
    end

    assign fifo_rd_valid_o = pop;
    assign m_valid_o       = (state_q != ST_EMPTY);
    assign m_data_o        = main_q;
    assign occupancy_o     = skid_occupancy(state_q);

endmodule

// File: tb/tb_fifo_rd_skid.sv
// Directed + randomized bench: depth-4 FWFT fifo model upstream, queue model of held words.
module tb_fifo_rd_skid;

    localparam int unsigned DW = 8;
    localparam int unsigned FIFO_DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] fifo_data_i = '0;
    logic          fifo_empty_i = 1'b1;
    logic          fifo_rd_valid_o;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_ready_i = 1'b0;
    logic [1:0]    occupancy_o;

    fifo_rd_skid #(.DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_data_i    (fifo_data_i),
        .fifo_empty_i   (fifo_empty_i),
        .fifo_rd_valid_o(fifo_rd_valid_o),
        .m_data_o       (m_data_o),
        .m_valid_o      (m_valid_o),
        .m_ready_i      (m_ready_i),
        .occupancy_o    (occupancy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fq[$];   // upstream fifo contents
    logic [DW-1:0] mq[$];   // words held by the stage, oldest first
    logic [DW-1:0] sb[$];   // every word pushed, in push order
    logic [DW-1:0] last_data = '0;
    logic [DW-1:0] prev_data = '0;
    bit            hold_prev = 1'b0;
    int            pops = 0;
    int            accepts = 0;
    int            cyc = 0;
    int            first_acc = -1;
    int            last_acc = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty_i = (fq.size() == 0);
        fifo_data_i  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] w);
        if (fq.size() < FIFO_DEPTH) begin
            fq.push_back(w);
            sb.push_back(w);
        end
        drive_fifo();
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic tick(input bit rdy);
        bit            exp_pop, dut_pop, dut_acc;
        logic [DW-1:0] head;
        m_ready_i = rdy;
        drive_fifo();
        #1;
        chk("m_valid", 32'(m_valid_o), 32'(mq.size() != 0));
        chk("m_data", 32'(m_data_o), 32'((mq.size() != 0) ? mq[0] : last_data));
        chk("occupancy", 32'(occupancy_o), 32'(mq.size()));
        exp_pop = (fq.size() != 0) && (mq.size() < 2);
        chk("pop", 32'(fifo_rd_valid_o), 32'(exp_pop));
        if (hold_prev) chk("stable", 32'(m_data_o), 32'(prev_data));
        dut_pop = fifo_rd_valid_o;
        dut_acc = m_valid_o && m_ready_i;
        if (dut_acc) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_empty: observed %0h expected none", m_data_o);
            end else begin
                chk("sb_order", 32'(m_data_o), 32'(sb.pop_front()));
            end
            accepts++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
        end
        hold_prev = m_valid_o && !m_ready_i;
        prev_data = m_data_o;
        head = (fq.size() != 0) ? fq[0] : '0;
        @(posedge clk);
        #1;
        cyc++;
        if (mq.size() != 0) begin
            last_data = mq[0];
            if (rdy) void'(mq.pop_front());
        end
        if (exp_pop) mq.push_back(head);
        if (mq.size() != 0) last_data = mq[0];
        if (dut_pop && fq.size() != 0) begin
            void'(fq.pop_front());
            pops++;
        end
        drive_fifo();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fq.delete(); mq.delete(); sb.delete();
        last_data = '0;
        hold_prev = 1'b0;
        m_ready_i = 1'b0;
        drive_fifo();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pushed;
        int p0, a0;
        do_reset();

        // reset values
        chk("rst_valid", 32'(m_valid_o), 0);
        chk("rst_data", 32'(m_data_o), 0);
        chk("rst_occ", 32'(occupancy_o), 0);
        chk("rst_pop", 32'(fifo_rd_valid_o), 0);

        // single word: pop in cycle 0, visible in cycle 1, empty in cycle 2
        push(8'h5A);
        #1;
        chk("single_pop", 32'(fifo_rd_valid_o), 1);
        chk("single_nv0", 32'(m_valid_o), 0);
        tick(1'b1);
        chk("single_v1", 32'(m_valid_o), 1);
        chk("single_d1", 32'(m_data_o), 32'h5A);
        tick(1'b1);
        chk("single_occ2", 32'(occupancy_o), 0);
        tick(1'b1);

        // streaming 0x01..0x08 with ready held high
        p0 = pops; a0 = accepts; first_acc = -1;
        for (int unsigned w = 1; w <= 4; w++) push(DW'(w));
        pushed = 4;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1);
            if (pushed < 8) begin
                pushed++;
                push(DW'(pushed));
            end
        end
        chk("stream_pops", 32'(pops - p0), 8);
        chk("stream_accepts", 32'(accepts - a0), 8);
        chk("stream_consecutive", 32'(last_acc - first_acc), 7);

        // backpressure fills main + skid
        push(8'h10); push(8'h11); push(8'h12);
        for (int i = 0; i < 4; i++) tick(1'b0);
        chk("bp_occ", 32'(occupancy_o), 2);
        chk("bp_nopop", 32'(fifo_rd_valid_o), 0);
        chk("bp_data", 32'(m_data_o), 32'h10);
        for (int i = 0; i < 5; i++) tick(1'b1);
        chk("bp_drained", 32'(sb.size()), 0);

        // fifo empty gap then resume
        push(8'h21); push(8'h22);
        for (int i = 0; i < 3; i++) tick(1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1);
        chk("gap_valid", 32'(m_valid_o), 0);
        chk("gap_nopop", 32'(fifo_rd_valid_o), 0);
        push(8'h77);
        tick(1'b1);
        chk("gap_resume_v", 32'(m_valid_o), 1);
        chk("gap_resume_d", 32'(m_data_o), 32'h77);
        tick(1'b1);

        // random ready / random pushes over 100 words
        a0 = accepts;
        pushed = 0;
        for (int i = 0; i < 3000; i++) begin
            if (pushed < 100 && fq.size() < FIFO_DEPTH && ($urandom % 2) == 0) begin
                push(DW'($urandom));
                pushed++;
            end
            if (pushed == 100 && sb.size() == 0 && mq.size() == 0) break;
            tick(1'($urandom % 2));
        end
        chk("rand_accepts", 32'(accepts - a0), 100);
        chk("rand_drained", 32'(sb.size()), 0);

        // async reset mid-cycle while holding two entries
        push(8'hA1); push(8'hA2); push(8'hA3);
        for (int i = 0; i < 4; i++) tick(1'b0);
        chk("pre_rst_occ", 32'(occupancy_o), 2);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(m_valid_o), 0);
        chk("async_rst_occ", 32'(occupancy_o), 0);
        chk("async_rst_data", 32'(m_data_o), 0);
        do_reset();
        tick(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
